alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station feeding the ALU. Holds up to 2^RS_SIZE_WIDTH dispatched ALU instructions and tracks operand dependencies on in-flight ROB entries. Captures results broadcast by the ALU and LSB completion buses. Each cycle it issues the lowest-indexed entry with both operands available, as one registered operation on the ALU input port.

## Interface
- RS_SIZE_WIDTH, 3, log2 of entry count (8 entries).
- Tag width T = `ROB_SIZE_WIDTH+1 bits, matching ALU `dependency`. Op width = `CALC_OP_L1_NUM_WIDTH (4).
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  reset; asynchronous, active-high.
- rdy_in  in  1  global enable; low freezes all state and outputs.
- need_flush_in  in  1  misprediction flush.
- dispatch_valid_in  in  1  new instruction this cycle.
- dispatch_op_L1_in  in  4  ALU primary op.
- dispatch_op_L2_in  in  1  ALU sub-op (add/sub, srl/sra).
- dispatch_vj_in, dispatch_vk_in  in  32  operand values; meaningful only when the matching q-busy bit is 0.
- dispatch_qj_busy_in, dispatch_qk_busy_in  in  1  operand still pending.
- dispatch_qj_in, dispatch_qk_in  in  T  producing ROB tag of a pending operand.
- dispatch_dest_in  in  T  ROB tag of this instruction.
- alu_cdb_ready_in  in  1  ALU result broadcast valid.
- alu_cdb_dep_in  in  T  ALU result tag.
- alu_cdb_value_in  in  32  ALU result value.
- lsb_cdb_ready_in, lsb_cdb_dep_in, lsb_cdb_value_in  in  1/T/32  load result broadcast.
- full_out  out  1  all entries busy (combinational from state).
- valid_out  out  1  ALU operation issued (drives ALU valid).
- opr1_out, opr2_out  out  32  operands.
- dependency_out  out  T  destination ROB tag.
- alu_op_L1_out  out  4  op.
- alu_op_L2_out  out  1  sub-op.

## Operation
- Entry state: busy, op_L1, op_L2, vj, vk, qj_busy, qk_busy, qj, qk, dest.
- Priority at each active edge (rdy_in=1): flush > issue/wakeup/dispatch.
- Flush: every busy bit and valid_out cleared. Dispatch and CDB inputs in the same cycle are ignored.
- Dispatch:
  - Written into the lowest-indexed free entry as seen at the start of the cycle.
  - An entry freed by issue in the same cycle is not reused until the next cycle.
  - Dispatch with full_out=1 is a protocol violation. The block drops it and holds state.
- Wakeup, per pending operand of every busy entry:
  - If alu_cdb_ready_in and the tag equals alu_cdb_dep_in, the operand takes alu_cdb_value_in and its busy bit clears.
  - The LSB bus is checked the same way, independently of the ALU bus.
  - Both buses matching one operand cannot occur (unique tags). If it does, the ALU bus wins.
- Dispatch-cycle forwarding: a dispatched pending operand whose tag matches a CDB broadcast in the same cycle is stored already resolved, with the CDB value.
- Issue:
  - Candidate = busy entry with both q-busy bits 0 in the registered state. Lowest index wins.
  - On issue, the outputs are registered, valid_out<=1, and the entry's busy bit clears.
  - With no candidate, valid_out<=0 and the other outputs hold.
  - An operand woken in cycle N is issuable from cycle N+1. No CDB-to-ALU bypass.
- No backpressure from the ALU: it accepts one operation per cycle.

## Timing
- Reset (async): all busy=0, valid_out=0, opr1_out=opr2_out=0, dependency_out=0, alu_op_L1_out=0, alu_op_L2_out=0, full_out=0. Reset mid-operation discards all entries immediately.
- Dispatch latency, ready operands: dispatch sampled at edge E0, valid_out high after E1, ALU result after E2.
- Wakeup latency: CDB broadcast at edge E0 clears the q-busy bit; the entry can issue at E1.
- rdy_in=0: no state change, outputs hold, including valid_out. The ALU also freezes, so no operation is duplicated.
- full_out reflects the registered busy bits. It falls in the cycle after an issue from a full station.
- Throughput: one dispatch and one issue per cycle, sustained.

## Test plan
- Reset then dispatch `add` with vj=5, vk=7, dest=3, no dependencies -> valid_out=1 one edge later with opr1=5, opr2=7, dependency_out=3, op_L1=0, op_L2=0. Entry freed.
- Dispatch `sub` with qj pending on tag 2. Broadcast ALU CDB tag 2, value 100, two cycles later -> issue exactly one cycle after the broadcast, with opr1=100.
- Dispatch with qk pending on tag 4 in the same cycle that the LSB CDB broadcasts tag 4, value 0xDEADBEEF -> entry stored resolved. Issue next cycle with opr2=0xDEADBEEF.
- Fill all 8 entries, all pending on tag 9 -> full_out=1. Broadcast tag 9 -> issue order is entries 0..7 on consecutive cycles, and full_out drops after the first issue.
- Partially filled station with one ready entry, need_flush_in=1 together with a dispatch -> next cycle all entries empty, valid_out=0, full_out=0, dispatch dropped.
- Hold rdy_in=0 for 3 cycles while a ready entry exists and a CDB broadcasts -> no issue and no wakeup during the stall. valid_out and outputs hold their values. Normal operation resumes on the first edge with rdy_in=1.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU.
// Holds pending ALU ops, snoops the ALU/LSB result buses, issues one op per cycle.
module alu_rs #(
  parameter int RS_SIZE_WIDTH  = 3,
  parameter int ROB_SIZE_WIDTH = 4,
  localparam int T = ROB_SIZE_WIDTH + 1,
  localparam int N = 1 << RS_SIZE_WIDTH
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          need_flush_in,
  input  logic          dispatch_valid_in,
  input  logic [3:0]    dispatch_op_L1_in,
  input  logic          dispatch_op_L2_in,
  input  logic [31:0]   dispatch_vj_in,
  input  logic [31:0]   dispatch_vk_in,
  input  logic          dispatch_qj_busy_in,
  input  logic          dispatch_qk_busy_in,
  input  logic [T-1:0]  dispatch_qj_in,
  input  logic [T-1:0]  dispatch_qk_in,
  input  logic [T-1:0]  dispatch_dest_in,
  input  logic          alu_cdb_ready_in,
  input  logic [T-1:0]  alu_cdb_dep_in,
  input  logic [31:0]   alu_cdb_value_in,
  input  logic          lsb_cdb_ready_in,
  input  logic [T-1:0]  lsb_cdb_dep_in,
  input  logic [31:0]   lsb_cdb_value_in,
  output logic          full_out,
  output logic          valid_out,
  output logic [31:0]   opr1_out,
  output logic [31:0]   opr2_out,
  output logic [T-1:0]  dependency_out,
  output logic [3:0]    alu_op_L1_out,
  output logic          alu_op_L2_out
);

  logic [N-1:0] busy;
  logic [N-1:0] qj_busy;
  logic [N-1:0] qk_busy;
  logic [3:0]   op_l1 [N];
  logic [N-1:0] op_l2;
  logic [31:0]  vj    [N];
  logic [31:0]  vk    [N];
  logic [T-1:0] qj    [N];
  logic [T-1:0] qk    [N];
  logic [T-1:0] dest  [N];

  logic                     has_free;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic                     has_iss;
  logic [RS_SIZE_WIDTH-1:0] iss_idx;

  logic        d_jb;
  logic        d_kb;
  logic [31:0] d_jv;
  logic [31:0] d_kv;

  assign full_out = &busy;

  // lowest free slot and lowest ready slot, from registered state only
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    has_iss  = 1'b0;
    iss_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        has_free = 1'b1;
        free_idx = RS_SIZE_WIDTH'(i);
      end
      if (busy[i] && !qj_busy[i] && !qk_busy[i]) begin
        has_iss = 1'b1;
        iss_idx = RS_SIZE_WIDTH'(i);
      end
    end
  end

  // resolve dispatched operands against same-cycle broadcasts
  always_comb begin
    d_jb = dispatch_qj_busy_in;
    d_jv = dispatch_vj_in;
    d_kb = dispatch_qk_busy_in;
    d_kv = dispatch_vk_in;
    if (dispatch_qj_busy_in) begin
      if (alu_cdb_ready_in && dispatch_qj_in == alu_cdb_dep_in) begin
        d_jb = 1'b0;
        d_jv = alu_cdb_value_in;
      end else if (lsb_cdb_ready_in &&
                   dispatch_qj_in == lsb_cdb_dep_in) begin
        d_jb = 1'b0;
        d_jv = lsb_cdb_value_in;
      end
    end
    if (dispatch_qk_busy_in) begin
      if (alu_cdb_ready_in && dispatch_qk_in == alu_cdb_dep_in) begin
        d_kb = 1'b0;
        d_kv = alu_cdb_value_in;
      end else if (lsb_cdb_ready_in &&
                   dispatch_qk_in == lsb_cdb_dep_in) begin
        d_kb = 1'b0;
        d_kv = lsb_cdb_value_in;
      end
    end
  end

  // entry storage: flush, wakeup, issue and dispatch
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy           <= '0;
      qj_busy        <= '0;
      qk_busy        <= '0;
      op_l2          <= '0;
      for (int i = 0; i < N; i++) begin
        op_l1[i] <= '0;
        vj[i]    <= '0;
        vk[i]    <= '0;
        qj[i]    <= '0;
        qk[i]    <= '0;
        dest[i]  <= '0;
      end
      valid_out      <= 1'b0;
      opr1_out       <= '0;
      opr2_out       <= '0;
      dependency_out <= '0;
      alu_op_L1_out  <= '0;
      alu_op_L2_out  <= 1'b0;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        busy      <= '0;
        valid_out <= 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (alu_cdb_ready_in && qj[i] == alu_cdb_dep_in) begin
              vj[i]      <= alu_cdb_value_in;
              qj_busy[i] <= 1'b0;
            end else if (lsb_cdb_ready_in &&
                         qj[i] == lsb_cdb_dep_in) begin
              vj[i]      <= lsb_cdb_value_in;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (alu_cdb_ready_in && qk[i] == alu_cdb_dep_in) begin
              vk[i]      <= alu_cdb_value_in;
              qk_busy[i] <= 1'b0;
            end else if (lsb_cdb_ready_in &&
                         qk[i] == lsb_cdb_dep_in) begin
              vk[i]      <= lsb_cdb_value_in;
              qk_busy[i] <= 1'b0;
            end
          end
        end
        if (has_iss) begin
          valid_out       <= 1'b1;
          opr1_out        <= vj[iss_idx];
          opr2_out        <= vk[iss_idx];
          dependency_out  <= dest[iss_idx];
          alu_op_L1_out   <= op_l1[iss_idx];
          alu_op_L2_out   <= op_l2[iss_idx];
          busy[iss_idx]   <= 1'b0;
        end else begin
          valid_out <= 1'b0;
        end
        if (dispatch_valid_in && has_free) begin
          busy[free_idx]    <= 1'b1;
          op_l1[free_idx]   <= dispatch_op_L1_in;
          op_l2[free_idx]   <= dispatch_op_L2_in;
          vj[free_idx]      <= d_jv;
          vk[free_idx]      <= d_kv;
          qj_busy[free_idx] <= d_jb;
          qk_busy[free_idx] <= d_kb;
          qj[free_idx]      <= dispatch_qj_in;
          qk[free_idx]      <= dispatch_qk_in;
          dest[free_idx]    <= dispatch_dest_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed checks for the ALU reservation station.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        dispatch_valid_in;
  logic [3:0]  dispatch_op_L1_in;
  logic        dispatch_op_L2_in;
  logic [31:0] dispatch_vj_in;
  logic [31:0] dispatch_vk_in;
  logic        dispatch_qj_busy_in;
  logic        dispatch_qk_busy_in;
  logic [4:0]  dispatch_qj_in;
  logic [4:0]  dispatch_qk_in;
  logic [4:0]  dispatch_dest_in;
  logic        alu_cdb_ready_in;
  logic [4:0]  alu_cdb_dep_in;
  logic [31:0] alu_cdb_value_in;
  logic        lsb_cdb_ready_in;
  logic [4:0]  lsb_cdb_dep_in;
  logic [31:0] lsb_cdb_value_in;
  logic        full_out;
  logic        valid_out;
  logic [31:0] opr1_out;
  logic [31:0] opr2_out;
  logic [4:0]  dependency_out;
  logic [3:0]  alu_op_L1_out;
  logic        alu_op_L2_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  alu_rs dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .need_flush_in       (need_flush_in),
    .dispatch_valid_in   (dispatch_valid_in),
    .dispatch_op_L1_in   (dispatch_op_L1_in),
    .dispatch_op_L2_in   (dispatch_op_L2_in),
    .dispatch_vj_in      (dispatch_vj_in),
    .dispatch_vk_in      (dispatch_vk_in),
    .dispatch_qj_busy_in (dispatch_qj_busy_in),
    .dispatch_qk_busy_in (dispatch_qk_busy_in),
    .dispatch_qj_in      (dispatch_qj_in),
    .dispatch_qk_in      (dispatch_qk_in),
    .dispatch_dest_in    (dispatch_dest_in),
    .alu_cdb_ready_in    (alu_cdb_ready_in),
    .alu_cdb_dep_in      (alu_cdb_dep_in),
    .alu_cdb_value_in    (alu_cdb_value_in),
    .lsb_cdb_ready_in    (lsb_cdb_ready_in),
    .lsb_cdb_dep_in      (lsb_cdb_dep_in),
    .lsb_cdb_value_in    (lsb_cdb_value_in),
    .full_out            (full_out),
    .valid_out           (valid_out),
    .opr1_out            (opr1_out),
    .opr2_out            (opr2_out),
    .dependency_out      (dependency_out),
    .alu_op_L1_out       (alu_op_L1_out),
    .alu_op_L2_out       (alu_op_L2_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    need_flush_in       = 1'b0;
    dispatch_valid_in   = 1'b0;
    dispatch_op_L1_in   = 4'd0;
    dispatch_op_L2_in   = 1'b0;
    dispatch_vj_in      = '0;
    dispatch_vk_in      = '0;
    dispatch_qj_busy_in = 1'b0;
    dispatch_qk_busy_in = 1'b0;
    dispatch_qj_in      = '0;
    dispatch_qk_in      = '0;
    dispatch_dest_in    = '0;
    alu_cdb_ready_in    = 1'b0;
    alu_cdb_dep_in      = '0;
    alu_cdb_value_in    = '0;
    lsb_cdb_ready_in    = 1'b0;
    lsb_cdb_dep_in      = '0;
    lsb_cdb_value_in    = '0;
  endtask

  task automatic disp(input logic [3:0] l1, input logic l2,
                      input logic [31:0] vj, input logic [31:0] vk,
                      input logic jb, input logic [4:0] qj,
                      input logic kb, input logic [4:0] qk,
                      input logic [4:0] dst);
    dispatch_valid_in   = 1'b1;
    dispatch_op_L1_in   = l1;
    dispatch_op_L2_in   = l2;
    dispatch_vj_in      = vj;
    dispatch_vk_in      = vk;
    dispatch_qj_busy_in = jb;
    dispatch_qj_in      = qj;
    dispatch_qk_busy_in = kb;
    dispatch_qk_in      = qk;
    dispatch_dest_in    = dst;
  endtask

  task automatic alu_bc(input logic [4:0] t, input logic [31:0] v);
    alu_cdb_ready_in = 1'b1;
    alu_cdb_dep_in   = t;
    alu_cdb_value_in = v;
  endtask

  initial begin
    idle();
    rdy_in = 1'b1;
    rst_in = 1'b1;
    #12;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_full", 32'(full_out), 32'd0);
    chk("rst_opr1", opr1_out, 32'd0);
    chk("rst_dep", 32'(dependency_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();

    // ready add
    disp(4'd0, 1'b0, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    step();
    idle();
    chk("add_lat0", 32'(valid_out), 32'd0);
    step();
    chk("add_valid", 32'(valid_out), 32'd1);
    chk("add_opr1", opr1_out, 32'd5);
    chk("add_opr2", opr2_out, 32'd7);
    chk("add_dep", 32'(dependency_out), 32'd3);
    chk("add_l1", 32'(alu_op_L1_out), 32'd0);
    chk("add_l2", 32'(alu_op_L2_out), 32'd0);
    step();
    chk("add_freed", 32'(valid_out), 32'd0);

    // sub waiting on ALU tag 2
    disp(4'd0, 1'b1, 32'd0, 32'd1, 1'b1, 5'd2, 1'b0, 5'd0, 5'd5);
    step();
    idle();
    step();
    chk("sub_wait", 32'(valid_out), 32'd0);
    alu_bc(5'd2, 32'd100);
    step();
    idle();
    chk("sub_nobyp", 32'(valid_out), 32'd0);
    step();
    chk("sub_valid", 32'(valid_out), 32'd1);
    chk("sub_opr1", opr1_out, 32'd100);
    chk("sub_opr2", opr2_out, 32'd1);
    chk("sub_l2", 32'(alu_op_L2_out), 32'd1);
    chk("sub_dep", 32'(dependency_out), 32'd5);
    step();

    // dispatch-cycle forward from LSB bus
    disp(4'd3, 1'b0, 32'd9, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 5'd6);
    lsb_cdb_ready_in = 1'b1;
    lsb_cdb_dep_in   = 5'd4;
    lsb_cdb_value_in = 32'hDEADBEEF;
    step();
    idle();
    step();
    chk("fwd_valid", 32'(valid_out), 32'd1);
    chk("fwd_opr2", opr2_out, 32'hDEADBEEF);
    chk("fwd_opr1", opr1_out, 32'd9);
    chk("fwd_l1", 32'(alu_op_L1_out), 32'd3);
    step();

    // fill all 8 entries on tag 9
    for (int i = 0; i < 8; i++) begin
      disp(4'd1, 1'b0, 32'd0, 32'(i), 1'b1, 5'd9, 1'b0, 5'd0,
           5'(16 + i));
      step();
    end
    idle();
    chk("fill_full", 32'(full_out), 32'd1);
    chk("fill_noiss", 32'(valid_out), 32'd0);
    disp(4'd2, 1'b0, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd31);
    step();
    idle();
    chk("full_drop", 32'(full_out), 32'd1);
    chk("full_drop_v", 32'(valid_out), 32'd0);
    alu_bc(5'd9, 32'h900);
    step();
    idle();
    chk("wake_full", 32'(full_out), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("ord_valid", 32'(valid_out), 32'd1);
      chk("ord_dep", 32'(dependency_out), 32'(16 + i));
      chk("ord_opr1", opr1_out, 32'h900);
      chk("ord_opr2", opr2_out, 32'(i));
      if (i == 0) chk("full_drop1", 32'(full_out), 32'd0);
    end
    step();
    chk("drain_valid", 32'(valid_out), 32'd0);

    // flush with pending + ready entries and a dispatch
    disp(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd11, 1'b0, 5'd0, 5'd7);
    step();
    disp(4'd0, 1'b0, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0, 5'd8);
    step();
    disp(4'd0, 1'b0, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 5'd0, 5'd10);
    need_flush_in = 1'b1;
    step();
    idle();
    chk("fl_valid", 32'(valid_out), 32'd0);
    chk("fl_full", 32'(full_out), 32'd0);
    step();
    chk("fl_nodisp", 32'(valid_out), 32'd0);
    alu_bc(5'd11, 32'd1);
    step();
    idle();
    step();
    chk("fl_empty", 32'(valid_out), 32'd0);

    // stall with rdy_in low
    disp(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd0, 5'd1);
    step();
    disp(4'd0, 1'b0, 32'h11, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd2);
    step();
    disp(4'd0, 1'b0, 32'h22, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
    step();
    idle();
    chk("st_pre_v", 32'(valid_out), 32'd1);
    chk("st_pre_o", opr1_out, 32'h11);
    rdy_in = 1'b0;
    alu_bc(5'd12, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_v", 32'(valid_out), 32'd1);
      chk("st_hold_o", opr1_out, 32'h11);
    end
    idle();
    rdy_in = 1'b1;
    step();
    chk("st_res_v", 32'(valid_out), 32'd1);
    chk("st_res_o", opr1_out, 32'h22);
    chk("st_res_d", 32'(dependency_out), 32'd3);
    step();
    chk("st_nowake", 32'(valid_out), 32'd0);
    alu_bc(5'd12, 32'h66);
    step();
    idle();
    step();
    chk("st_late_v", 32'(valid_out), 32'd1);
    chk("st_late_o", opr1_out, 32'h66);

    // async reset mid-operation
    disp(4'd0, 1'b0, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd4);
    step();
    idle();
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_opr1", opr1_out, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    step();
    step();
    chk("arst_empty", 32'(valid_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
